uart_frame_tx: RTL and testbench
================================

UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10416, SHALL set clock cycles per serial bit (100 MHz / 9600 baud); legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8, SHALL set data bits per character; legal range 5..9.
REQ-003 Parameter NUM_BYTES, default 2, SHALL set the maximum characters per frame; legal range 1..16.
REQ-004 Parameter PARITY, default 0, SHALL select parity: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, SHALL set stop bits per character; legal values 1, 2.
REQ-006 clock  input  1  SHALL be the sole clock; all logic is rising-edge.
REQ-007 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-008 tx_data  input  NUM_BYTES*DATA_BITS  SHALL carry frame payload; character k = tx_data[k*DATA_BITS +: DATA_BITS].
REQ-009 tx_len  input  $clog2(NUM_BYTES)+1  SHALL give the number of characters to send, 1..NUM_BYTES.
REQ-010 tx_valid  input  1  SHALL request transmission of tx_data/tx_len.
REQ-011 tx_ready  output  1  SHALL indicate a request can be accepted.
REQ-012 busy  output  1  SHALL be high while a frame is on the line.
REQ-013 done  output  1  SHALL pulse one cycle at frame completion.
REQ-014 TxD  output  1  SHALL be the serial line, idle high.

Function
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-016 Acceptance SHALL occur on a cycle with tx_valid=1 and tx_ready=1; tx_ready SHALL equal (state==IDLE).
REQ-017 On acceptance, tx_data and tx_len SHALL be captured; later input changes SHALL have no effect on the frame in flight.
REQ-018 tx_valid with tx_len=0 or tx_len>NUM_BYTES SHALL be ignored: no acceptance, tx_ready stays high, no done.
REQ-019 TxD SHALL go low (start bit) on the cycle after acceptance (latency 1).
REQ-020 Each bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a baud counter cleared on acceptance.
REQ-021 Data bits SHALL be sent LSB first; characters SHALL be sent in order 0..tx_len-1.
REQ-022 Parity bit SHALL be XOR of the character's data bits (even) or its inverse (odd).
REQ-023 STOP SHALL drive TxD high for STOP_BITS*CLKS_PER_BIT cycles.
REQ-024 After a non-final character's stop bit(s), START of the next character SHALL follow with no idle gap.
REQ-025 Frame length SHALL be tx_len*(1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles exactly.
REQ-026 After the final stop bit, the FSM SHALL enter IDLE; done SHALL be 1 for that first IDLE cycle only.
REQ-027 A new request SHALL be acceptable in the same cycle done is high, giving a minimum idle-high gap of 1 cycle between frames.
REQ-028 tx_valid while busy SHALL be ignored; no queuing.
REQ-029 busy SHALL be high from the cycle after acceptance through the last stop-bit cycle.
REQ-030 In IDLE, TxD SHALL be 1.

Reset
REQ-031 With reset high, outputs SHALL next be TxD=1, tx_ready=1, busy=0, done=0; FSM=IDLE; counters cleared.
REQ-032 Reset mid-frame SHALL abort immediately with TxD=1 on the next cycle; no done pulse for the aborted frame.
REQ-033 tx_valid SHALL be ignored in any cycle where reset is high.

Verification (CLKS_PER_BIT=4, DATA_BITS=8, NUM_BYTES=2 unless stated)
REQ-034 PARITY=0, tx_len=2, tx_data=16'hA55A: line SHALL show 0,5A LSB-first,1,0,A5 LSB-first,1; 80 cycles; one done pulse.
REQ-035 PARITY=2, tx_len=1, tx_data[7:0]=8'h07: parity bit SHALL be 1; frame 44 cycles. With PARITY=1, parity bit SHALL be 0.
REQ-036 STOP_BITS=2, tx_len=1, data 8'hFF: TxD high 8 cycles after the data bits; frame 44 cycles.
REQ-037 tx_valid held high continuously, tx_len=1: frames SHALL repeat with exactly 1 idle-high cycle between them; tx_data changed mid-frame SHALL not alter the current frame.
REQ-038 tx_len=0 with tx_valid=1: TxD stays 1, tx_ready stays 1, no done.
REQ-039 Reset asserted 10 cycles into a frame: TxD=1 next cycle, busy=0, no done; next request SHALL transmit normally.

Source files
------------

// File: rtl/uart_frame_tx_if.sv
// Frame-request handshake and serial line bundle for uart_frame_tx.
interface uart_frame_tx_if #(
  parameter int DATA_BITS = 8,
  parameter int NUM_BYTES = 2
);
  localparam int LW = $clog2(NUM_BYTES) + 1;

  logic [NUM_BYTES*DATA_BITS-1:0] tx_data;
  logic [LW-1:0]                  tx_len;
  logic                           tx_valid;
  logic                           tx_ready;
  logic                           busy;
  logic                           done;
  logic                           TxD;

  modport master (
    output tx_data, tx_len, tx_valid,
    input  tx_ready, busy, done, TxD
  );

  modport slave (
    input  tx_data, tx_len, tx_valid,
    output tx_ready, busy, done, TxD
  );
endinterface

// File: rtl/uart_frame_tx.sv
// Multi-character UART transmitter: start, LSB-first data, optional
// parity and stop bits per character, one done pulse per frame.
module uart_frame_tx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int NUM_BYTES    = 2,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clock,
  input  logic             reset,
  uart_frame_tx_if.slave   bus
);
  localparam int FW = NUM_BYTES * DATA_BITS;
  localparam int LW = $clog2(NUM_BYTES) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [LW-1:0] chr_q, chr_d;
  logic [LW-1:0] len_q, len_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          par_q, par_d;
  logic          done_q, done_d;

  logic bit_end;
  logic len_ok;
  logic accept;
  logic odd;
  logic txd;

  assign odd     = (PARITY == 1);
  assign bit_end = (baud_q == 16'(CLKS_PER_BIT - 1));
  assign len_ok  = (bus.tx_len != '0) &&
                   (bus.tx_len <= LW'(NUM_BYTES));
  assign accept  = (state_q == S_IDLE) &&
                   bus.tx_valid && len_ok;

  assign bus.tx_ready = (state_q == S_IDLE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.TxD      = txd;

  // frame_q shifts one bit per data bit, so the
  // current character always sits at the bottom.
  always_comb begin
    txd = 1'b1;
    unique case (state_q)
      S_START: txd = 1'b0;
      S_DATA:  txd = frame_q[0];
      S_PAR:   txd = par_q ^ odd;
      default: txd = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 16'd1;
    bit_d   = bit_q;
    chr_d   = chr_q;
    len_d   = len_q;
    frame_d = frame_q;
    par_d   = par_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (accept) begin
          state_d = S_START;
          frame_d = bus.tx_data;
          len_d   = bus.tx_len;
          chr_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        par_d = 1'b0;
        bit_d = '0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          frame_d = frame_q >> 1;
          par_d   = par_q ^ frame_q[0];
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (chr_q == len_q - LW'(1)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              chr_d   = chr_q + LW'(1);
              state_d = S_START;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      chr_q   <= '0;
      len_q   <= '0;
      frame_q <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      chr_q   <= chr_d;
      len_q   <= len_d;
      frame_q <= frame_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: four parity/stop variants,
// expected line/busy/done per cycle queued when a request is driven.
module tb_uart_frame_tx;
  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] tx_data = '0;
  logic [1:0]  tx_len = '0;
  logic        tx_valid = 1'b0;
  int          sel = 0;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [2:0] exp_q[$];

  always #5 clock = ~clock;

  uart_frame_tx_if #(.DATA_BITS(8), .NUM_BYTES(2)) b0 ();
  uart_frame_tx_if #(.DATA_BITS(8), .NUM_BYTES(2)) b1 ();
  uart_frame_tx_if #(.DATA_BITS(8), .NUM_BYTES(2)) b2 ();
  uart_frame_tx_if #(.DATA_BITS(8), .NUM_BYTES(2)) b3 ();

  assign b0.tx_data = tx_data;
  assign b0.tx_len = tx_len;
  assign b0.tx_valid = tx_valid;
  assign b1.tx_data = tx_data;
  assign b1.tx_len = tx_len;
  assign b1.tx_valid = tx_valid;
  assign b2.tx_data = tx_data;
  assign b2.tx_len = tx_len;
  assign b2.tx_valid = tx_valid;
  assign b3.tx_data = tx_data;
  assign b3.tx_len = tx_len;
  assign b3.tx_valid = tx_valid;

  uart_frame_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .NUM_BYTES(2),
    .PARITY(0), .STOP_BITS(1)) u0 (.clock(clock), .reset(reset), .bus(b0));
  uart_frame_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .NUM_BYTES(2),
    .PARITY(2), .STOP_BITS(1)) u1 (.clock(clock), .reset(reset), .bus(b1));
  uart_frame_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .NUM_BYTES(2),
    .PARITY(1), .STOP_BITS(1)) u2 (.clock(clock), .reset(reset), .bus(b2));
  uart_frame_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .NUM_BYTES(2),
    .PARITY(0), .STOP_BITS(2)) u3 (.clock(clock), .reset(reset), .bus(b3));

  logic txd_m, busy_m, done_m, ready_m;
  assign txd_m = (sel == 0) ? b0.TxD : (sel == 1) ? b1.TxD :
                 (sel == 2) ? b2.TxD : b3.TxD;
  assign busy_m = (sel == 0) ? b0.busy : (sel == 1) ? b1.busy :
                  (sel == 2) ? b2.busy : b3.busy;
  assign done_m = (sel == 0) ? b0.done : (sel == 1) ? b1.done :
                  (sel == 2) ? b2.done : b3.done;
  assign ready_m = (sel == 0) ? b0.tx_ready : (sel == 1) ? b1.tx_ready :
                   (sel == 2) ? b2.tx_ready : b3.tx_ready;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s (dut %0d): observed %0h expected %0h",
             tag, sel, obs, exp);
    end
  endtask

  task automatic rep(logic [2:0] v, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Entries are {TxD, busy, done}, one per clock after acceptance.
  task automatic push_frame(logic [15:0] d, int l, int p, int s);
    logic [7:0] c;
    logic       pb;
    for (int k = 0; k < l; k++) begin
      c = d[k*8 +: 8];
      rep(3'b010, CPB);
      for (int b = 0; b < 8; b++) rep({c[b], 2'b10}, CPB);
      if (p != 0) begin
        pb = (p == 1) ? ~^c : ^c;
        rep({pb, 2'b10}, CPB);
      end
      rep(3'b110, s * CPB);
    end
    rep(3'b101, 1);
  endtask

  task automatic drain(int n);
    logic [2:0] e;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      chk("line_busy_done", {29'd0, txd_m, busy_m, done_m}, {29'd0, e});
    end
  endtask

  task automatic drain_all();
    drain(exp_q.size());
  endtask

  task automatic req(logic [15:0] d, logic [1:0] l, bit keep);
    @(negedge clock);
    tx_data = d;
    tx_len = l;
    tx_valid = 1'b1;
    chk("ready_before_accept", {31'd0, ready_m}, 32'd1);
    @(posedge clock);
    #1;
    if (!keep) begin
      tx_valid = 1'b0;
      tx_data = ~d;
      tx_len = 2'd2;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    tx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held with a valid request pending: nothing may start
    tx_valid = 1'b1;
    tx_len = 2'd1;
    tx_data = 16'h00FF;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_state", {29'd0, txd_m, busy_m, done_m}, 32'h4);
    chk("reset_ready", {31'd0, ready_m}, 32'd1);
    tx_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_idle", {29'd0, txd_m, busy_m, done_m}, 32'h4);

    // two-character frame, no parity
    sel = 0;
    push_frame(16'hA55A, 2, 0, 1);
    req(16'hA55A, 2'd2, 1'b0);
    drain_all();
    chk("a55a_frame_len_80", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    chk("after_done_idle", {29'd0, txd_m, busy_m, done_m}, 32'h4);

    push_frame(16'h003C, 1, 0, 1);
    req(16'h003C, 2'd1, 1'b0);
    drain_all();

    // illegal lengths are ignored
    @(negedge clock);
    tx_len = 2'd0;
    tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("len0_idle", {29'd0, txd_m, busy_m, done_m}, 32'h4);
      chk("len0_ready", {31'd0, ready_m}, 32'd1);
    end
    tx_len = 2'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("len3_idle", {29'd0, txd_m, busy_m, done_m}, 32'h4);
    end
    tx_valid = 1'b0;

    // valid held: back-to-back frames, data swapped mid-frame
    do_reset();
    sel = 0;
    push_frame(16'h0096, 1, 0, 1);
    push_frame(16'h0041, 1, 0, 1);
    rep(3'b100, 2);
    req(16'h0096, 2'd1, 1'b1);
    drain(5);
    tx_data = 16'h0041;
    drain(36);
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
    tx_data = 16'h00FF;
    drain_all();

    // even parity
    do_reset();
    sel = 1;
    push_frame(16'h0007, 1, 2, 1);
    req(16'h0007, 2'd1, 1'b0);
    drain_all();
    push_frame(16'h0003, 1, 2, 1);
    req(16'h0003, 2'd1, 1'b0);
    drain_all();

    // odd parity
    do_reset();
    sel = 2;
    push_frame(16'h0007, 1, 1, 1);
    req(16'h0007, 2'd1, 1'b0);
    drain_all();
    push_frame(16'hE100, 2, 1, 1);
    req(16'hE100, 2'd2, 1'b0);
    drain_all();

    // two stop bits, then a second character right behind
    do_reset();
    sel = 3;
    push_frame(16'h00FF, 1, 0, 2);
    req(16'h00FF, 2'd1, 1'b0);
    drain_all();
    push_frame(16'h5500, 2, 0, 2);
    req(16'h5500, 2'd2, 1'b0);
    drain_all();

    // reset 10 cycles into a frame
    do_reset();
    sel = 0;
    push_frame(16'h00C3, 1, 0, 1);
    req(16'h00C3, 2'd1, 1'b0);
    drain(10);
    exp_q.delete();
    reset = 1'b1;
    @(negedge clock);
    chk("abort_state", {29'd0, txd_m, busy_m, done_m}, 32'h4);
    chk("abort_ready", {31'd0, ready_m}, 32'd1);
    reset = 1'b0;
    rep(3'b100, 4);
    drain_all();
    push_frame(16'h0081, 1, 0, 1);
    req(16'h0081, 2'd1, 1'b0);
    drain_all();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
